// File: rtl/multi_digit_counter_display_if.sv
// Control and display signals of the multi-digit counter/display block.
// The master side drives the count controls; the slave side is the block itself.
interface multi_digit_counter_display_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up_down;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  wrap;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     an;

  modport master (
    output en, up_down, load, load_val,
    input  count, wrap, seg, an
  );

  modport slave (
    input  en, up_down, load, load_val,
    output count, wrap, seg, an
  );
endinterface

// File: rtl/multi_digit_counter_display.sv
// N-digit BCD/hex up/down counter driven by a programmable tick prescaler,
// with a time-multiplexed seven-segment scan driver on a shared segment bus.
module multi_digit_counter_display #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 24000000,
  parameter int SCAN_DIV = 50000,
  parameter int BCD      = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  multi_digit_counter_display_if.slave    bus
);

  localparam int CW = 4 * DIGITS;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [3:0]    DMAX      = (BCD != 0) ? 4'd9 : 4'd15;

  // Seven-segment pattern for one digit, bit6=g .. bit0=a, active high.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0: seg_decode = 7'h3F;
      4'h1: seg_decode = 7'h06;
      4'h2: seg_decode = 7'h5B;
      4'h3: seg_decode = 7'h4F;
      4'h4: seg_decode = 7'h66;
      4'h5: seg_decode = 7'h6D;
      4'h6: seg_decode = 7'h7D;
      4'h7: seg_decode = 7'h07;
      4'h8: seg_decode = 7'h7F;
      4'h9: seg_decode = 7'h6F;
      4'hA: seg_decode = 7'h77;
      4'hB: seg_decode = 7'h7C;
      4'hC: seg_decode = 7'h39;
      4'hD: seg_decode = 7'h5E;
      4'hE: seg_decode = 7'h79;
      default: seg_decode = 7'h71;
    endcase
  endfunction

  // In decimal mode an out-of-range loaded digit is forced to zero so the
  // counter never holds a non-decimal digit.
  function automatic logic [CW-1:0] sanitize(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if ((BCD != 0) && (v[4*i +: 4] > 4'd9)) r[4*i +: 4] = 4'd0;
    end
    return r;
  endfunction

  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [CW-1:0]     count_q, count_d;
  logic              wrap_q, wrap_d;
  logic              tick, scan_term, carry;
  logic [3:0]        dg, cur_digit;

  assign tick      = (tick_cnt_q == TICK_LAST);
  assign scan_term = (scan_cnt_q == SCAN_LAST);

  // Tick prescaler and counter next state: load beats step; a step ripples
  // carry/borrow through all digits in one cycle, a carry out of the top
  // digit is the full-range wrap.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    carry      = 1'b0;
    dg         = 4'd0;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    if (bus.load) begin
      count_d    = sanitize(bus.load_val);
      tick_cnt_d = '0;
    end else if (tick && bus.en) begin
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        dg = count_q[4*i +: 4];
        if (carry) begin
          if (bus.up_down) begin
            if (dg == DMAX) dg = 4'd0;
            else begin
              dg    = dg + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (dg == 4'd0) dg = DMAX;
            else begin
              dg    = dg - 4'd1;
              carry = 1'b0;
            end
          end
        end
        count_d[4*i +: 4] = dg;
      end
      wrap_d = carry;
    end
  end

  // Scan prescaler, digit index and registered one-hot digit select.
  always_comb begin
    scan_cnt_d = scan_term ? '0 : scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    if (scan_term) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    an_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) an_d[i] = 1'b1;
    end
  end

  // Digit currently being shown, straight from the registered count.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) cur_digit = count_q[4*i +: 4];
    end
  end

  // State registers; reset returns everything to digit 0 showing zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= DIGITS'(1);
      count_q    <= '0;
      wrap_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.an    = an_q;
  assign bus.seg   = seg_decode(cur_digit);

endmodule

// File: tb/tb_multi_digit_counter_display.sv
// Bench for multi_digit_counter_display: a decimal and a hex instance run on
// the same randomized stimulus against an arithmetic reference model.
module tb_multi_digit_counter_display;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int CW       = 4 * DIGITS;

  typedef struct {
    logic [CW-1:0]     count;
    logic              wrap;
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_digit_counter_display_if #(.DIGITS(DIGITS)) bus_b ();
  multi_digit_counter_display_if #(.DIGITS(DIGITS)) bus_h ();

  multi_digit_counter_display #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV),
    .SCAN_DIV(SCAN_DIV), .BCD(1)) dut_bcd (.clk(clk), .rst(rst), .bus(bus_b));
  multi_digit_counter_display #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV),
    .SCAN_DIV(SCAN_DIV), .BCD(0)) dut_hex (.clk(clk), .rst(rst), .bus(bus_h));

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  exp_t q0[$];
  exp_t q1[$];
  int   total  = 0;
  int   passed = 0;

  // Model: each counter is an integer modulo base**DIGITS.
  int val[2];
  int tph = 0;
  int k   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  task automatic model_edge(input logic r, input logic e, input logic ud,
                            input logic ld, input logic [CW-1:0] lv);
    bit   tick;
    int   idx;
    exp_t ex;
    tick = (tph == TICK_DIV - 1);
    if (r || ld) tph = 0;
    else         tph = (tph + 1) % TICK_DIV;
    if (r) k = 0;
    else   k = (k + 1) % (SCAN_DIV * DIGITS);
    idx = (k / SCAN_DIV) % DIGITS;
    for (int d = 0; d < 2; d++) begin
      int base;
      int range;
      int wr;
      base  = (d == 0) ? 10 : 16;
      range = base ** DIGITS;
      wr    = 0;
      if (r) val[d] = 0;
      else if (ld) begin
        val[d] = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
          int dgt;
          dgt = int'((lv >> (4 * i)) & 15);
          if (d == 0 && dgt > 9) dgt = 0;
          val[d] = val[d] * base + dgt;
        end
      end else if (tick && e) begin
        if (ud) begin
          wr     = (val[d] == range - 1) ? 1 : 0;
          val[d] = (val[d] + 1) % range;
        end else begin
          wr     = (val[d] == 0) ? 1 : 0;
          val[d] = (val[d] + range - 1) % range;
        end
      end
      ex.count = '0;
      for (int i = 0; i < DIGITS; i++)
        ex.count[4*i +: 4] = 4'((val[d] / (base ** i)) % base);
      ex.wrap = wr[0];
      ex.an   = DIGITS'(1) << idx;
      ex.seg  = tbl[ex.count[4*idx +: 4]];
      if (d == 0) q0.push_back(ex);
      else        q1.push_back(ex);
    end
  endtask

  // Apply one cycle of inputs to both instances and record expectations.
  task automatic drv(input logic r, input logic e, input logic ud,
                     input logic ld, input logic [CW-1:0] lv);
    rst = r;
    bus_b.en = e;  bus_b.up_down = ud;  bus_b.load = ld;  bus_b.load_val = lv;
    bus_h.en = e;  bus_h.up_down = ud;  bus_h.load = ld;  bus_h.load_val = lv;
    model_edge(r, e, ud, ld, lv);
    @(negedge clk);
  endtask

  // Monitor: every edge each instance presents a new output set.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        ex = q0.pop_front();
        chk("bcd_count", 32'(bus_b.count), 32'(ex.count));
        chk("bcd_wrap",  32'(bus_b.wrap),  32'(ex.wrap));
        chk("bcd_an",    32'(bus_b.an),    32'(ex.an));
        chk("bcd_seg",   32'(bus_b.seg),   32'(ex.seg));
      end
      if (q1.size() > 0) begin
        ex = q1.pop_front();
        chk("hex_count", 32'(bus_h.count), 32'(ex.count));
        chk("hex_wrap",  32'(bus_h.wrap),  32'(ex.wrap));
        chk("hex_an",    32'(bus_h.an),    32'(ex.an));
        chk("hex_seg",   32'(bus_h.seg),   32'(ex.seg));
      end
    end
  end

  initial begin
    logic [CW-1:0] lv;
    drv(1, 0, 1, 0, '0);
    drv(1, 1, 1, 1, 8'h55);
    // Count up through 99 -> 00 (decimal wrap).
    repeat (420) drv(0, 1, 1, 0, '0);
    // Count down, including 00 -> 99 after a reset.
    drv(1, 1, 0, 0, '0);
    repeat (20) drv(0, 1, 0, 0, '0);
    // Out-of-range decimal digit on load.
    drv(0, 1, 1, 1, 8'h3C);
    repeat (6) drv(0, 1, 1, 0, '0);
    // Hex FE -> FF -> 00 with wrap.
    drv(0, 1, 1, 1, 8'hFE);
    repeat (12) drv(0, 1, 1, 0, '0);
    // Load on a tick cycle wins over the step.
    while (tph != TICK_DIV - 1) drv(0, 1, 1, 0, '0);
    drv(0, 1, 1, 1, 8'h98);
    repeat (9) drv(0, 1, 1, 0, '0);
    // Enable low: count frozen while prescaler runs.
    repeat (20) drv(0, 0, 1, 0, '0);
    repeat (9) drv(0, 1, 1, 0, '0);
    // Scan of 47 on the hex instance, then reset mid-scan.
    drv(0, 0, 1, 1, 8'h47);
    repeat (9) drv(0, 0, 1, 0, '0);
    drv(1, 1, 1, 0, '0);
    repeat (3) drv(0, 1, 1, 0, '0);
    // Randomized operation.
    for (int n = 0; n < 1500; n++) begin
      lv = CW'($urandom);
      drv(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 5) != 0), ($urandom_range(0, 39) == 0), lv);
    end
    drv(0, 0, 1, 0, '0);
    @(negedge clk);
    chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
